oqpsk_tx_sequencer: RTL and testbench

Bit-stream sequencer for the OQPSK raised-cosine modulator. Accepts payload bytes from the host into a small FIFO, serializes them MSB-first onto the modulator's `Bit_In`, and generates the modulator's `EN` and `REQ_SAMPLE` controls at a programmable sample rate. It also appends a zero-bit flush tail so the pulse-shaping filter drains, and it flags FIFO underrun.

---
 rtl/oqpsk_tx_sequencer.sv | 150 +++++++++++++++
 tb/tb_oqpsk_tx_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oqpsk_tx_sequencer.sv
// Payload FIFO plus bit serializer driving the OQPSK modulator.
// Generates EN / REQ_SAMPLE / Bit_In and appends a zero flush tail.
module oqpsk_tx_sequencer #(
  parameter int DIV_W      = 16,
  parameter int SPB        = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int FLUSH_BITS = 4
) (
  input  logic             ACK,
  input  logic             RST,
  input  logic [DIV_W-1:0] CFG_DIV,
  input  logic             START,
  input  logic             STOP,
  input  logic [7:0]       DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             EN,
  output logic             REQ_SAMPLE,
  output logic             Bit_In,
  output logic             BUSY,
  output logic             UNDERRUN
);

  localparam int SW = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d, tmr_q, tmr_d;
  logic [SW-1:0]    smp_q, smp_d;
  logic [7:0]       bcnt_q, bcnt_d, shr_q, shr_d;
  logic             stop_q, stop_d, unr_q, unr_d;

  logic push, pop, tick, bit_end, byte_end, start_ok, has_data;

  assign has_data = (cnt_q != '0);
  assign push     = DIN_VALID & DIN_READY;
  assign tick     = (state_q != S_IDLE) && (tmr_q == '0);
  assign bit_end  = tick && (smp_q == SW'(SPB - 1));
  assign byte_end = bit_end && (state_q == S_RUN) && (bcnt_q == 8'd7);
  assign start_ok = (state_q == S_IDLE) && START && has_data;
  assign pop      = start_ok | (byte_end & ~stop_q & has_data);

  always_ff @(posedge ACK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      tmr_q   <= '0;
      smp_q   <= '0;
      bcnt_q  <= '0;
      shr_q   <= '0;
      stop_q  <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tmr_q   <= tmr_d;
      smp_q   <= smp_d;
      bcnt_q  <= bcnt_d;
      shr_q   <= shr_d;
      stop_q  <= stop_d;
      unr_q   <= unr_d;
    end
  end

  // Storage needs no reset; emptiness lives in the pointers and count.
  always_ff @(posedge ACK) begin
    if (push) mem[wptr_q] <= DIN;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (byte_end && (stop_q || !has_data)) state_d = S_FLUSH;
      S_FLUSH: if (bit_end && bcnt_q == 8'(FLUSH_BITS - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    div_d  = div_q;
    tmr_d  = tmr_q;
    smp_d  = smp_q;
    bcnt_d = bcnt_q;
    shr_d  = shr_q;
    stop_d = stop_q;
    unr_d  = unr_q;
    if (start_ok) begin
      div_d  = CFG_DIV;
      tmr_d  = CFG_DIV;
      smp_d  = '0;
      bcnt_d = '0;
      shr_d  = mem[rptr_q];
      stop_d = STOP;
      unr_d  = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (tick) begin
        tmr_d = div_q;
        smp_d = smp_q + SW'(1);
      end else begin
        tmr_d = tmr_q - DIV_W'(1);
      end
      if (state_q == S_RUN && STOP) stop_d = 1'b1;
      if (bit_end && state_q == S_RUN) begin
        if (bcnt_q == 8'd7) begin
          bcnt_d = '0;
          if (stop_q) stop_d = 1'b0;
          else if (has_data) shr_d = mem[rptr_q];
          else unr_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
          shr_d  = {shr_q[6:0], 1'b0};
        end
      end else if (bit_end) begin
        if (bcnt_q == 8'(FLUSH_BITS - 1)) begin
          bcnt_d = '0;
          tmr_d  = '0;
          smp_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    DIN_READY  = (cnt_q != CW'(FIFO_DEPTH));
    EN         = (state_q != S_IDLE);
    BUSY       = (state_q != S_IDLE);
    REQ_SAMPLE = tick;
    Bit_In     = (state_q == S_RUN) & shr_q[7];
    UNDERRUN   = unr_q;
  end

endmodule

// File: tb/tb_oqpsk_tx_sequencer.sv
// Directed bench for oqpsk_tx_sequencer with a bit scoreboard.
// Expected bits are queued as bytes are written and popped per bit.
module tb_oqpsk_tx_sequencer;
  localparam int SPB = 32;
  localparam int FB  = 4;

  logic        ACK = 1'b0;
  logic        RST;
  logic [15:0] CFG_DIV;
  logic        START, STOP, DIN_VALID;
  logic [7:0]  DIN;
  logic        DIN_READY, EN, REQ_SAMPLE, Bit_In, BUSY, UNDERRUN;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pc    = 0;
  int t0, n, len;
  bit sb[$];

  oqpsk_tx_sequencer #(
    .DIV_W(16), .SPB(SPB), .FIFO_DEPTH(4), .FLUSH_BITS(FB)
  ) dut (
    .ACK(ACK), .RST(RST), .CFG_DIV(CFG_DIV),
    .START(START), .STOP(STOP), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .EN(EN), .REQ_SAMPLE(REQ_SAMPLE), .Bit_In(Bit_In),
    .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  always #5 ACK = ~ACK;
  always @(posedge ACK) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // First request of every bit period carries that bit's value.
  always @(negedge ACK) begin
    if (RST || !EN) begin
      pc = 0;
    end else if (REQ_SAMPLE) begin
      if (pc % SPB == 0) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) check("bit", Bit_In, sb.pop_front());
      end
      pc++;
    end
  end

  task automatic tick();
    @(posedge ACK);
    #1;
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sb.push_back(b[i]);
  endtask

  task automatic exp_flush();
    for (int i = 0; i < FB; i++) sb.push_back(1'b0);
  endtask

  task automatic wr(input logic [7:0] b);
    int k = 0;
    while (!DIN_READY && k < 5000) begin tick(); k++; end
    DIN = b;
    DIN_VALID = 1'b1;
    tick();
    DIN_VALID = 1'b0;
  endtask

  task automatic go(input logic stp);
    START = 1'b1;
    STOP  = stp;
    tick();
    START = 1'b0;
    STOP  = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_req(output int k);
    k = 0;
    while (!REQ_SAMPLE && k < 100) begin tick(); k++; end
  endtask

  task automatic wait_done(output int l);
    int k = 0;
    while (EN && k < 20000) begin tick(); k++; end
    l = cyc - t0;
  endtask

  task automatic wait_cyc(input int tgt);
    while (cyc < tgt) tick();
  endtask

  task automatic check_reset(string tag);
    check({tag, "_en"}, EN, 0);
    check({tag, "_req"}, REQ_SAMPLE, 0);
    check({tag, "_bit"}, Bit_In, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_unr"}, UNDERRUN, 0);
    check({tag, "_rdy"}, DIN_READY, 1);
  endtask

  initial begin
    RST = 1'b1;
    CFG_DIV = 16'd3;
    START = 1'b0;
    STOP = 1'b0;
    DIN = 8'h00;
    DIN_VALID = 1'b0;
    repeat (2) @(posedge ACK);
    #1;
    check_reset("rst0");
    RST = 1'b0;
    tick();

    // single byte, divider 3
    CFG_DIV = 16'd3;
    wr(8'hA5);
    exp_byte(8'hA5);
    exp_flush();
    go(1'b1);
    check("t2_busy", BUSY, 1);
    check("t2_en", EN, 1);
    check("t2_first_bit", Bit_In, 1);
    wait_req(n);
    check("t2_first_req", n, 3);
    tick();
    wait_req(n);
    check("t2_req_period", n + 1, 4);
    wait_done(len);
    check("t2_frame_len", len, 1536);
    check("t2_unr", UNDERRUN, 0);
    check("t2_idle", BUSY, 0);

    // full FIFO, fifth byte held off until the first pop
    CFG_DIV = 16'd0;
    for (int i = 1; i <= 4; i++) begin
      wr(8'(i));
      exp_byte(8'(i));
    end
    check("t3_full", DIN_READY, 0);
    DIN = 8'h05;
    DIN_VALID = 1'b1;
    go(1'b0);
    check("t3_rdy_after_pop", DIN_READY, 1);
    tick();
    DIN_VALID = 1'b0;
    check("t3_full_again", DIN_READY, 0);
    exp_byte(8'h05);
    exp_flush();
    wait_cyc(t0 + 4 * 256 + 50);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    wait_done(len);
    check("t3_frame_len", len, 44 * 32);
    check("t3_unr", UNDERRUN, 0);

    // underrun after two bytes
    CFG_DIV = 16'd1;
    wr(8'hFF);
    wr(8'h00);
    exp_byte(8'hFF);
    exp_byte(8'h00);
    exp_flush();
    go(1'b0);
    wait_cyc(t0 + 16 * 64 - 1);
    check("t4_unr_before", UNDERRUN, 0);
    tick();
    check("t4_unr_at_bound", UNDERRUN, 1);
    check("t4_flush_en", EN, 1);
    check("t4_flush_bit", Bit_In, 0);
    wait_done(len);
    check("t4_frame_len", len, 20 * 64);
    check("t4_unr_sticky", UNDERRUN, 1);
    go(1'b0);
    check("t4_empty_start", BUSY, 0);
    check("t4_unr_kept", UNDERRUN, 1);

    // divider latched only at START
    CFG_DIV = 16'd0;
    wr(8'h3C);
    exp_byte(8'h3C);
    exp_flush();
    go(1'b1);
    check("t5_unr_clr", UNDERRUN, 0);
    check("t5_req0", REQ_SAMPLE, 1);
    tick();
    check("t5_req1", REQ_SAMPLE, 1);
    CFG_DIV = 16'd9;
    repeat (5) tick();
    check("t5_req_after_chg", REQ_SAMPLE, 1);
    wait_done(len);
    check("t5_frame_len0", len, 12 * 32);
    wr(8'hC3);
    exp_byte(8'hC3);
    exp_flush();
    go(1'b1);
    wait_req(n);
    check("t5_first_req9", n, 9);
    wait_done(len);
    check("t5_frame_len9", len, 12 * 320);

    // STOP mid byte 1 leaves two bytes queued
    CFG_DIV = 16'd0;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    exp_byte(8'h11);
    exp_flush();
    go(1'b0);
    wait_cyc(t0 + 100);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    wait_done(len);
    check("t6_frame_len", len, 12 * 32);
    check("t6_rdy", DIN_READY, 1);
    wr(8'h44);
    check("t6_rdy_cnt3", DIN_READY, 1);
    wr(8'h55);
    check("t6_full_cnt4", DIN_READY, 0);
    exp_byte(8'h22);
    exp_byte(8'h33);
    exp_byte(8'h44);
    exp_byte(8'h55);
    exp_flush();
    go(1'b0);
    wait_done(len);
    check("t6_rest_len", len, 36 * 32);
    check("t6_unr", UNDERRUN, 1);

    // async reset mid RUN with bytes queued
    wr(8'hAA);
    wr(8'hBB);
    wr(8'hCC);
    exp_byte(8'hAA);
    exp_byte(8'hBB);
    exp_byte(8'hCC);
    go(1'b0);
    check("t1_running", EN, 1);
    repeat (50) tick();
    #2;
    RST = 1'b1;
    #1;
    check_reset("t1_async");
    sb.delete();
    tick();
    RST = 1'b0;
    tick();
    go(1'b0);
    check("t1_start_ignored", BUSY, 0);
    repeat (3) tick();
    check("t1_en_low", EN, 0);
    check("t1_rdy", DIN_READY, 1);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
